// File: rtl/seg7_pkg.sv
// Shared types and hex-to-segment mapping for the multiplexed 7-segment driver.
// Segment vectors are active-high gfedcba (bit0 = a); polarity is applied at the pins.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  function automatic seg_t hex2seg(input logic [3:0] nibble);
    seg_t s;
    case (nibble)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-high segment pattern; zero latency, no flow control.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg7_hex_mux.sv
// N-digit hex display scanner with double-buffered load, guard slot and optional leading-zero blanking.
// Pins are registered (1 cycle after scan state); no backpressure. SEG7_DIM_EN adds bright_i duty control.
module seg7_hex_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int REFRESH_HZ  = 1_000,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
`ifdef SEG7_DIM_EN
  input  logic [3:0]            bright_i,
`endif
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  pend_o,
  output logic                  frame_o
);

  localparam int TICK_DIV = CLK_HZ / (REFRESH_HZ * N_DIGITS);
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic SEG_INV = (SEG_ACT_LOW != 0);
  localparam logic AN_INV  = (AN_ACT_LOW != 0);
  localparam seg_t SEG_OFF = SEG_BLANK ^ {7{SEG_INV}};
  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_INV}};

  if (TICK_DIV < 2) begin : g_tick_div_chk
    $error("seg7_hex_mux: TICK_DIV must be at least 2");
  end

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] pend_val, disp_val, upper;
  logic [N_DIGITS-1:0]   pend_dp, disp_dp, an_v;
  logic                  tick, last, commit, en, lz_blank;
  logic [3:0]            nibble;
  seg_t                  dec_seg;

  assign tick   = (cnt == CW'(TICK_DIV - 1));
  assign last   = (idx == IW'(N_DIGITS - 1));
  assign commit = tick && last && pend_o;

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef SEG7_DIM_EN
  localparam int MW = $clog2(TICK_DIV * 16 + 1);
  logic [3:0]    bright_q;
  logic [MW-1:0] duty_lhs, duty_rhs;

  // Compare cnt/TICK_DIV against (bright+1)/16 without a divider.
  assign duty_lhs = MW'(cnt) << 4;
  assign duty_rhs = MW'(TICK_DIV) * (MW'(bright_q) + MW'(1));
  assign en       = (cnt != '0) && (duty_lhs < duty_rhs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bright_q <= 4'hF;
    else if (commit) bright_q <= bright_i;
  end
`else
  assign en = (cnt != '0);
`endif

  always_comb begin
    nibble   = disp_val[{idx, 2'b00} +: 4];
    upper    = disp_val >> {idx, 2'b00};
    lz_blank = blank_lz_i && (idx != '0) && (upper == '0);
    an_v     = '0;
    if (en) an_v[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      pend_o   <= 1'b0;
      frame_o  <= 1'b0;
      an_o     <= AN_OFF;
      seg_o    <= SEG_OFF;
      dp_o     <= SEG_INV;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= last ? '0 : idx + 1'b1;
      frame_o <= commit;
      if (commit) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        pend_o   <= 1'b0;
      end
      // A load in the commit cycle lands after the swap and is shown next frame.
      if (load_i) begin
        pend_val <= value_i;
        pend_dp  <= dp_i;
        pend_o   <= 1'b1;
      end
      an_o  <= an_v ^ AN_OFF;
      seg_o <= (lz_blank ? SEG_BLANK : dec_seg) ^ {7{SEG_INV}};
      dp_o  <= (!lz_blank && disp_dp[idx]) ^ SEG_INV;
    end
  end

endmodule

// File: tb/tb_seg7_hex_mux.sv
// Bench for seg7_hex_mux at TICK_DIV=4, four digits, active-low pins; define SEG7_DIM_EN for the dimming cases.
module tb_seg7_hex_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_i = '0;
  logic [3:0]  dp_i = '0;
  logic        load_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic [3:0]  bright_i = 4'hF;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        pend_o;
  logic        frame_o;

  always #5 clk = ~clk;

  seg7_hex_mux #(
    .N_DIGITS(4), .CLK_HZ(1600), .REFRESH_HZ(100), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .value_i(value_i), .dp_i(dp_i), .load_i(load_i),
    .blank_lz_i(blank_lz_i),
`ifdef SEG7_DIM_EN
    .bright_i(bright_i),
`endif
    .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o), .pend_o(pend_o), .frame_o(frame_o)
  );

  int checks = 0;
  int failures = 0;

  // Active-high gfedcba patterns for 0..F.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: cycle number since reset release plus the two buffers.
  int          n;
  logic [15:0] m_pval, m_dval;
  logic [3:0]  m_pdp, m_ddp;
  logic        m_pend;
  int          m_bright;
  int          frames;

  logic [6:0]  cap_seg [4];
  logic        cap_dp [4];
  int          an_cnt [4];

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        lz;
    logic [27:0] segs;   // {d3, d2, d1, d0}, pin levels
    logic [3:0]  dpo;    // {d3, d2, d1, d0}, pin levels
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; m_pval = '0; m_dval = '0; m_pdp = '0; m_ddp = '0; m_pend = 1'b0; m_bright = 15;
  endtask

  task automatic clear_cap();
    for (int k = 0; k < 4; k++) begin
      cap_seg[k] = 7'h00; cap_dp[k] = 1'b0; an_cnt[k] = 0;
    end
  endtask

  task automatic step();
    int c, d;
    logic en, blank, commit, exp_dp;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    c = n % 4;
    d = (n / 4) % 4;
    en = (c != 0);
`ifdef SEG7_DIM_EN
    en = en && (c * 16 < 4 * (m_bright + 1));
`endif
    exp_an  = en ? ~(4'b0001 << d) : 4'hF;
    blank   = blank_lz_i && (d > 0) && ((m_dval >> (4 * d)) == 16'h0);
    exp_seg = blank ? 7'h7F : ~seg_tab[m_dval[4*d +: 4]];
    exp_dp  = blank ? 1'b1 : ~m_ddp[d];
    commit  = (n % 16 == 15) && m_pend;
    if (commit) begin
      m_dval = m_pval; m_ddp = m_pdp; m_pend = 1'b0; m_bright = int'(bright_i);
    end
    if (load_i) begin
      m_pval = value_i; m_pdp = dp_i; m_pend = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("scan", {18'd0, an_o, seg_o, dp_o, pend_o, frame_o},
          {18'd0, exp_an, exp_seg, exp_dp, m_pend, commit});
    if (frame_o) frames++;
    for (int k = 0; k < 4; k++) begin
      if (an_o == ~(4'b0001 << k)) begin
        cap_seg[k] = seg_o; cap_dp[k] = dp_o; an_cnt[k]++;
      end
    end
    n++;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < 16 && (n % 16) != phase; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    value_i = v; dp_i = p; load_i = 1'b1;
    step();
    load_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h12AF, 4'b0101, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1010};
    vecs[1] = '{16'h0030, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b1100};
    vecs[2] = '{16'h0000, 4'b0010, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    vecs[4] = '{16'h8005, 4'b1000, 1'b1, {7'h00, 7'h40, 7'h40, 7'h12}, 4'b0111};

    model_reset();
    frames = 0;
    clear_cap();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {18'd0, an_o, seg_o, dp_o, pend_o, frame_o}, {18'd0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    model_reset();

    run(20);

    // Table-driven vectors: load, let it commit, then capture one whole frame.
    for (int v = 0; v < 5; v++) begin
      blank_lz_i = vecs[v].lz;
      do_load(vecs[v].val, vecs[v].dp);
      check("pend_after_load", {31'd0, pend_o}, 32'd1);
      run(20);
      clear_cap();
      run(16);
      for (int k = 0; k < 4; k++) begin
        check("vec_seg", {25'd0, cap_seg[k]}, {25'd0, vecs[v].segs[7*k +: 7]});
        check("vec_dp", {31'd0, cap_dp[k]}, {31'd0, vecs[v].dpo[k]});
        check("vec_an_cycles", an_cnt[k], 3);
      end
    end
    blank_lz_i = 1'b0;

    // Two loads inside one frame: last wins, single frame pulse.
    align(0);
    frames = 0;
    do_load(16'h1111, 4'h0);
    run(3);
    do_load(16'h2222, 4'h0);
    run(27);
    clear_cap();
    run(16);
    check("double_load_frames", frames, 1);
    for (int k = 0; k < 4; k++) check("double_load_seg", {25'd0, cap_seg[k]}, {25'd0, 7'h24});

    // Load landing exactly in the commit cycle.
    align(2);
    do_load(16'h4444, 4'h0);
    align(15);
    do_load(16'h3333, 4'h0);
    check("commit_cycle_frame", {31'd0, frame_o}, 32'd1);
    check("commit_cycle_pend", {31'd0, pend_o}, 32'd1);
    clear_cap();
    run(16);
    check("commit_cycle_old", {25'd0, cap_seg[0]}, {25'd0, 7'h19});
    clear_cap();
    run(16);
    check("commit_cycle_new", {25'd0, cap_seg[0]}, {25'd0, 7'h30});

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      load_i  = ($urandom_range(7) == 0);
      value_i = 16'($urandom);
      dp_i    = 4'($urandom);
      if ($urandom_range(31) == 0) blank_lz_i = ~blank_lz_i;
      step();
    end
    load_i = 1'b0;
    blank_lz_i = 1'b0;

    // Reset mid-scan with a pending load outstanding.
    align(5);
    do_load(16'h5555, 4'hF);
    run(2);
    rst = 1'b1;
    #1;
    check("midscan_reset", {18'd0, an_o, seg_o, dp_o, pend_o, frame_o}, {18'd0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(40);

`ifdef SEG7_DIM_EN
    bright_i = 4'd7;
    do_load(16'h1234, 4'h0);
    run(20);
    clear_cap();
    run(16);
    for (int k = 0; k < 4; k++) check("dim7_an_cycles", an_cnt[k], 1);
    bright_i = 4'd0;
    do_load(16'h4321, 4'h0);
    run(20);
    clear_cap();
    run(16);
    for (int k = 0; k < 4; k++) check("dim0_an_cycles", an_cnt[k], 0);
    bright_i = 4'hF;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
